// File: rtl/if_fetch_unit_pkg.sv
// rtl/if_fetch_unit_pkg.sv - shared constants and FSM encoding for the fetch stage
package if_fetch_unit_pkg;

    // Active level of the asynchronous reset input.
    localparam logic RESET_ENABLE = 1'b0;

    // Level of a stall vector bit that holds a stage.
    localparam logic STALL_ENABLE  = 1'b1;
    localparam logic STALL_DISABLE = ~STALL_ENABLE;

    localparam logic [31:0] NOP_INSTRUCTION = 32'h0000_0000;
    localparam logic [31:0] PC_INCREMENT    = 32'd4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_WAIT = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/if_next_pc.sv
// rtl/if_next_pc.sv - next fetch address select: pending redirect, live branch, or pc+4
//
// Ports:
//   pc            current fetch address
//   redir_valid   a branch arrived while the delay slot was still in flight
//   redir_target  target recorded for that branch
//   branch_flag   ID-stage taken branch this cycle
//   branch_target ID-stage redirect address
//   next_pc       address to fetch after the word at pc is captured
module if_next_pc
    import if_fetch_unit_pkg::*;
(
    input  logic [31:0] pc,
    input  logic        redir_valid,
    input  logic [31:0] redir_target,
    input  logic        branch_flag,
    input  logic [31:0] branch_target,
    output logic [31:0] next_pc
);

    // A recorded redirect is older than any live branch, so it wins.
    // The increment wraps naturally at 32 bits.
    always_comb begin
        next_pc = pc + PC_INCREMENT;
        if (redir_valid) begin
            next_pc = redir_target;
        end else if (branch_flag) begin
            next_pc = branch_target;
        end
    end

endmodule

// File: rtl/if_fetch_unit.sv
// rtl/if_fetch_unit.sv - instruction fetch stage with one-word buffer and delay-slot redirects
//
// Ports:
//   clock, reset       posedge clock, asynchronous active-low reset
//   stall[5:0]         pipeline stall vector; only stall[1] (IF/ID hold) is used
//   branch_flag        ID-stage taken branch this cycle
//   branch_target      ID-stage redirect address
//   imem_req/addr      fetch request and address (address is always pc)
//   imem_ack/rdata     memory response; ack is ignored while imem_req is low
//   if_pc_read_data    address of the buffered instruction
//   if_instruction     buffered instruction, NOP_WORD while the buffer is empty
//   stallreq_if        high while no instruction is buffered
module if_fetch_unit
    import if_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_WORD = NOP_INSTRUCTION
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [5:0]  stall,
    input  logic        branch_flag,
    input  logic [31:0] branch_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] if_pc_read_data,
    output logic [31:0] if_instruction,
    output logic        stallreq_if
);

    fetch_state_t state, state_next;

    logic [31:0] pc;
    logic        fb_valid;
    logic [31:0] fb_pc;
    logic [31:0] fb_instr;
    logic        redir_valid;
    logic [31:0] redir_target;

    logic        consume;
    logic        room;
    logic        capture;
    logic [31:0] next_pc;

    // Only the IF/ID hold bit matters here; the rest of the vector is for other stages.
    logic unused_stall_bits;
    assign unused_stall_bits = ^{stall[5:2], stall[0]};

    // IF/ID takes the buffered word at this edge.
    assign consume = fb_valid && (stall[1] == STALL_DISABLE);
    assign room    = !fb_valid || consume;
    assign capture = imem_req && imem_ack;

    if_next_pc u_next_pc (
        .pc            (pc),
        .redir_valid   (redir_valid),
        .redir_target  (redir_target),
        .branch_flag   (branch_flag),
        .branch_target (branch_target),
        .next_pc       (next_pc)
    );

    always_comb begin
        state_next = state;
        imem_req   = 1'b0;
        case (state)
            ST_IDLE: begin
                state_next = ST_RUN;
            end
            ST_RUN: begin
                // With a valid buffer the branch's delay slot is already held,
                // so the word at pc must not be fetched; pc is redirected instead.
                imem_req = room && !(branch_flag && fb_valid);
                if (imem_req && !imem_ack) begin
                    state_next = ST_WAIT;
                end
            end
            ST_WAIT: begin
                // Request and address stay stable until the memory answers.
                imem_req = 1'b1;
                if (imem_ack) begin
                    state_next = ST_RUN;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (reset == RESET_ENABLE) begin
            state        <= ST_IDLE;
            pc           <= RESET_PC;
            fb_valid     <= 1'b0;
            fb_pc        <= 32'h0000_0000;
            fb_instr     <= NOP_WORD;
            redir_valid  <= 1'b0;
            redir_target <= 32'h0000_0000;
        end else begin
            state <= state_next;
            if (capture) begin
                fb_instr    <= imem_rdata;
                fb_pc       <= pc;
                fb_valid    <= 1'b1;
                pc          <= next_pc;
                redir_valid <= 1'b0;
            end else begin
                if (consume) begin
                    fb_valid <= 1'b0;
                end
                if (branch_flag && state != ST_IDLE) begin
                    if (fb_valid) begin
                        pc <= branch_target;
                    end else begin
                        // Delay slot still in flight at pc: apply the target after it lands.
                        redir_valid  <= 1'b1;
                        redir_target <= branch_target;
                    end
                end
            end
        end
    end

    assign imem_addr       = pc;
    assign if_pc_read_data = fb_pc;
    assign if_instruction  = fb_valid ? fb_instr : NOP_WORD;
    assign stallreq_if     = !fb_valid;

endmodule
